// File: rtl/pc_sequencer.sv
// Fetch-side program counter: sequential stepping, execute-stage redirects with a
// counted pipeline flush, link-address capture for jal/jalr, and trapping on bad targets.
module pc_sequencer #(
  parameter logic [9:0]  RESET_PC     = 10'h000,
  parameter logic [9:0]  TRAP_VECTOR  = 10'h3F0,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic [1:0]  redirect_kind,
  input  logic [31:0] redirect_target,
  input  logic [9:0]  redirect_pc,
  input  logic        trap_clear,
  output logic [9:0]  pc,
  output logic        pc_valid,
  output logic        flush,
  output logic [9:0]  link_addr,
  output logic        link_valid,
  output logic        trap,
  output logic [31:0] trap_addr
);

  localparam int unsigned PC_W   = 10;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned ADDR_W = 32;
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(FLUSH_CYCLES - 1);

  typedef enum logic [1:0] {
    BOOT  = 2'b00,
    RUN   = 2'b01,
    FLUSH = 2'b10,
    TRAP  = 2'b11
  } state_t;

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [PC_W-1:0]    pc_n, link_addr_n;
  logic               pc_valid_n, flush_n, link_valid_n, trap_n;
  logic [ADDR_W-1:0]  trap_addr_n;
  logic               redirect_present_c;
  logic               target_bad_c;

  assign redirect_present_c = |redirect_kind;
  assign target_bad_c       = (|redirect_target[1:0]) || (|redirect_target[31:10]);

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= BOOT;
      cnt        <= '0;
      pc         <= RESET_PC;
      pc_valid   <= 1'b0;
      flush      <= 1'b0;
      link_addr  <= '0;
      link_valid <= 1'b0;
      trap       <= 1'b0;
      trap_addr  <= '0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      pc         <= pc_n;
      pc_valid   <= pc_valid_n;
      flush      <= flush_n;
      link_addr  <= link_addr_n;
      link_valid <= link_valid_n;
      trap       <= trap_n;
      trap_addr  <= trap_addr_n;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    pc_n         = pc;
    pc_valid_n   = pc_valid;
    flush_n      = flush;
    link_addr_n  = link_addr;
    link_valid_n = 1'b0;
    trap_n       = trap;
    trap_addr_n  = trap_addr;

    case (state)
      BOOT: begin
        state_n    = RUN;
        pc_valid_n = 1'b1;
        flush_n    = 1'b0;
      end

      RUN, FLUSH: begin
        if (redirect_present_c) begin
          // Redirect wins over stall and over an in-progress flush
          pc_valid_n = 1'b0;
          if (target_bad_c) begin
            state_n     = TRAP;
            trap_n      = 1'b1;
            trap_addr_n = redirect_target;
            flush_n     = 1'b0;
          end else begin
            state_n = FLUSH;
            pc_n    = redirect_target[PC_W-1:0];
            flush_n = 1'b1;
            cnt_n   = CNT_RELOAD;
          end
          if (redirect_kind[1]) begin
            link_addr_n  = redirect_pc + PC_W'(4);
            link_valid_n = 1'b1;
          end
        end else if (state == RUN) begin
          pc_valid_n = 1'b1;
          flush_n    = 1'b0;
          if (!stall) pc_n = pc + PC_W'(4);
        end else if (cnt == '0) begin
          state_n    = RUN;
          flush_n    = 1'b0;
          pc_valid_n = 1'b1;
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end

      TRAP: begin
        pc_valid_n = 1'b0;
        flush_n    = 1'b0;
        if (trap_clear) begin
          state_n = FLUSH;
          pc_n    = TRAP_VECTOR;
          trap_n  = 1'b0;
          flush_n = 1'b1;
          cnt_n   = CNT_RELOAD;
        end
      end

      default: state_n = BOOT;
    endcase
  end

endmodule
